matrix_loader: RTL and testbench

Byte-stream writer for the systolic-array operands. It receives a framed stream of weight and data elements over a valid/ready handshake and assembles them into the two packed matrices that `sys_array_fetcher` consumes (`input_data_w`, `input_data_b`). It replaces the fixed ROM source on the operand side, so new matrices can be loaded at run time from a UART or a host bridge. Outputs change only on a complete, accepted frame; a partial or corrupt frame never disturbs matrices already presented to the fetcher.

---
 rtl/matrix_loader.sv | 181 ++++++++++++++++++
 tb/tb_matrix_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Framed byte-stream writer for the systolic-array weight and data matrices.
// Optional trailing checksum is enabled with `define MATRIX_LOADER_CHECKSUM_EN.
module matrix_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 2,
  parameter int ARRAY_W_L  = 5,
  parameter int ARRAY_A_W  = 5,
  parameter int ARRAY_A_L  = 2,
  parameter int HEADER     = 'hA5
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic                                               in_valid,
  input  logic [DATA_WIDTH-1:0]                              in_data,
  output logic                                               in_ready,
  output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] data_rom_w,
  output logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] data_rom_b,
  output logic                                               load_done,
  output logic                                               loaded,
  output logic                                               err,
  output logic [2:0]                                         dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_valid may be held high, in_ready drops only for the COMMIT cycle.

  localparam int MAX_R = (ARRAY_W_W > ARRAY_A_W) ? ARRAY_W_W : ARRAY_A_W;
  localparam int MAX_C = (ARRAY_W_L > ARRAY_A_L) ? ARRAY_W_L : ARRAY_A_L;
  localparam int RW    = (MAX_R > 1) ? $clog2(MAX_R) : 1;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [DATA_WIDTH-1:0] HDR = DATA_WIDTH'(HEADER);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
`ifdef MATRIX_LOADER_CHECKSUM_EN
    CHECK,
`endif
    COMMIT
  } state_t;

  state_t                                               state_q;
  logic [RW-1:0]                                        row_q, row_d;
  logic [CW-1:0]                                        col_q, col_d;
  logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]  shadow_w_q, rom_w_q;
  logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]  shadow_b_q, rom_b_q;
  logic                                                 in_ready_q;
  logic                                                 load_done_q;
  logic                                                 loaded_q;
  logic                                                 accept;
  logic                                                 end_of_row;
  logic                                                 end_of_mat;
  logic [CW-1:0]                                        cols_last;
  logic [RW-1:0]                                        rows_last;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]                                acc_q;
  logic                                                 err_q;
`endif

  assign accept = in_valid && in_ready_q;

  // Counter bounds follow whichever matrix is being filled; wrap without division.
  always_comb begin
    cols_last  = (state_q == LOAD_B) ? CW'(ARRAY_A_L - 1) : CW'(ARRAY_W_L - 1);
    rows_last  = (state_q == LOAD_B) ? RW'(ARRAY_A_W - 1) : RW'(ARRAY_W_W - 1);
    end_of_row = (col_q == cols_last);
    end_of_mat = end_of_row && (row_q == rows_last);
    col_d      = end_of_row ? '0 : col_q + 1'b1;
    row_d      = end_of_mat ? '0 : (end_of_row ? row_q + 1'b1 : row_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      shadow_w_q  <= '0;
      shadow_b_q  <= '0;
      rom_w_q     <= '0;
      rom_b_q     <= '0;
      in_ready_q  <= 1'b1;
      load_done_q <= 1'b0;
      loaded_q    <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      acc_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      load_done_q <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept && (in_data == HDR)) begin
            state_q <= LOAD_W;
            row_q   <= '0;
            col_q   <= '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        LOAD_W: begin
          if (accept) begin
            for (int r = 0; r < ARRAY_W_W; r++)
              for (int c = 0; c < ARRAY_W_L; c++)
                if ((row_q == RW'(r)) && (col_q == CW'(c)))
                  shadow_w_q[r][c] <= in_data;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            acc_q <= acc_q + in_data;
`endif
            row_q <= row_d;
            col_q <= col_d;
            if (end_of_mat) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            for (int r = 0; r < ARRAY_A_W; r++)
              for (int c = 0; c < ARRAY_A_L; c++)
                if ((row_q == RW'(r)) && (col_q == CW'(c)))
                  shadow_b_q[r][c] <= in_data;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            acc_q <= acc_q + in_data;
`endif
            row_q <= row_d;
            col_q <= col_d;
            if (end_of_mat) begin
`ifdef MATRIX_LOADER_CHECKSUM_EN
              state_q    <= CHECK;
`else
              state_q    <= COMMIT;
              in_ready_q <= 1'b0;
`endif
            end
          end
        end
`ifdef MATRIX_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (in_data == acc_q) begin
              state_q    <= COMMIT;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        COMMIT: begin
          rom_w_q     <= shadow_w_q;
          rom_b_q     <= shadow_b_q;
          load_done_q <= 1'b1;
          loaded_q    <= 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign data_rom_w = rom_w_q;
  assign data_rom_b = rom_b_q;
  assign load_done  = load_done_q;
  assign loaded     = loaded_q;
  assign dbg_state  = state_q;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader (2x5 weights, 5x2 data).
// Works with or without MATRIX_LOADER_CHECKSUM_EN defined.
module tb_matrix_loader;

  localparam logic [7:0] HDR = 8'hA5;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_COMMIT = 3'd4;
  localparam int         EXP_ERRS  = 1;
`else
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam int         EXP_ERRS  = 0;
`endif

  logic                     clk;
  logic                     reset_n;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic [0:1][0:4][7:0]     data_rom_w;
  logic [0:4][0:1][7:0]     data_rom_b;
  logic                     load_done;
  logic                     loaded;
  logic                     err;
  logic [2:0]               dbg_state;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int rdy_low  = 0;
  int ld_cnt   = 0;
  bit mon_en   = 0;

  logic [7:0] exp_q[$];

  matrix_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .data_rom_w (data_rom_w),
    .data_rom_b (data_rom_b),
    .load_done  (load_done),
    .loaded     (loaded),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset / monitors
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (mon_en) begin
      if (in_ready === 1'b0) rdy_low++;
      if (load_done === 1'b1) ld_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] first, input logic [7:0] ck_delta);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(HDR);
    for (int i = 0; i < 20; i++) begin
      send_byte(first + 8'(i));
      sum = sum + first + 8'(i);
    end
`ifdef MATRIX_LOADER_CHECKSUM_EN
    send_byte(sum + ck_delta);
`else
    if (ck_delta != 8'h00) $display("note: checksum delta ignored, no checksum byte");
`endif
  endtask

  task automatic push_exp(input logic [7:0] first);
    for (int i = 0; i < 20; i++) exp_q.push_back(first + 8'(i));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // tests
  task automatic test_reset();
    int nz;
    do_reset();
    nz = 0;
    for (int i = 0; i < 10; i++) if (data_rom_w[i/5][i%5] !== 8'h00) nz++;
    for (int i = 0; i < 10; i++) if (data_rom_b[i/2][i%2] !== 8'h00) nz++;
    checks++;
    if (nz != 0) begin failures++; $display("FAIL reset_roms: nonzero=%0d required 0", nz); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    checks++;
    if ({load_done, loaded, err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b exp 000", {load_done, loaded, err});
    end
    checks++;
    if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_good_frame();
    int mism;
    logic [7:0] e, a;
    push_exp(8'd1);
    send_frame(8'd1, 8'h00);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || load_done !== 1'b0 || dbg_state !== ST_COMMIT) begin
      failures++;
      $display("FAIL good_at_E: ready=%b done=%b state=%0d exp 0 0 %0d", in_ready, load_done, dbg_state, ST_COMMIT);
    end
    @(posedge clk); #1;
    checks++;
    if (load_done !== 1'b1 || loaded !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL good_at_E1: done=%b loaded=%b ready=%b exp 1 1 1", load_done, loaded, in_ready);
    end
    checks++;
    if (data_rom_w[0][0] !== 8'd1 || data_rom_w[1][4] !== 8'd10 || data_rom_b[4][1] !== 8'd20) begin
      failures++;
      $display("FAIL good_corners: w00=%0d w14=%0d b41=%0d exp 1 10 20", data_rom_w[0][0], data_rom_w[1][4], data_rom_b[4][1]);
    end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      a = (i < 10) ? data_rom_w[i/5][i%5] : data_rom_b[(i-10)/2][(i-10)%2];
      if (a !== e) mism++;
    end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL good_matrix: mismatches=%0d exp 0", mism); end
    @(posedge clk); #1;
    checks++;
    if (load_done !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL good_at_E2: done=%b err=%b exp 0 0", load_done, err);
    end
  endtask

`ifdef MATRIX_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    int mism;
    logic [7:0] e, a;
    push_exp(8'd1);
    send_frame(8'd1, 8'h01);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || dbg_state !== 3'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bad_at_E: err=%b state=%0d ready=%b exp 1 0 1", err, dbg_state, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || load_done !== 1'b0 || loaded !== 1'b1) begin
      failures++; $display("FAIL bad_at_E1: err=%b done=%b loaded=%b exp 0 0 1", err, load_done, loaded);
    end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      a = (i < 10) ? data_rom_w[i/5][i%5] : data_rom_b[(i-10)/2][(i-10)%2];
      if (a !== e) mism++;
    end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL bad_outputs_kept: mismatches=%0d exp 0", mism); end
  endtask
`endif

  task automatic test_discard();
    int mism;
    logic [7:0] e, a;
    send_byte(8'h00);
    send_byte(8'h7F);
    checks++;
    if (dbg_state !== 3'd0) begin failures++; $display("FAIL discard_idle: state=%0d exp 0", dbg_state); end
    push_exp(8'd50);
    send_frame(8'd50, 8'h00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (load_done !== 1'b1) begin failures++; $display("FAIL discard_commit: done=%b exp 1", load_done); end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      a = (i < 10) ? data_rom_w[i/5][i%5] : data_rom_b[(i-10)/2][(i-10)%2];
      if (a !== e) mism++;
    end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL discard_matrix: mismatches=%0d exp 0", mism); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int mism;
    logic [7:0] e, a;
    rdy_low = 0;
    ld_cnt  = 0;
    mon_en  = 1'b1;
    push_exp(8'd100);
    push_exp(8'd200);
    send_frame(8'd100, 8'h00);
    in_data = HDR;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (load_done !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_first_commit: done=%b ready=%b exp 1 1", load_done, in_ready);
    end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      a = (i < 10) ? data_rom_w[i/5][i%5] : data_rom_b[(i-10)/2][(i-10)%2];
      if (a !== e) mism++;
    end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL b2b_first_matrix: mismatches=%0d exp 0", mism); end
    send_frame(8'd200, 8'h00);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (rdy_low != 2 || ld_cnt != 2) begin
      failures++; $display("FAIL b2b_counts: ready_low=%0d commits=%0d exp 2 2", rdy_low, ld_cnt);
    end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      a = (i < 10) ? data_rom_w[i/5][i%5] : data_rom_b[(i-10)/2][(i-10)%2];
      if (a !== e) mism++;
    end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL b2b_second_matrix: mismatches=%0d exp 0", mism); end
  endtask

  task automatic test_reset_mid();
    int nz, mism;
    logic [7:0] e, a;
    send_byte(HDR);
    for (int i = 0; i < 7; i++) send_byte(8'd30 + 8'(i));
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 10; i++) if (data_rom_w[i/5][i%5] !== 8'h00) nz++;
    for (int i = 0; i < 10; i++) if (data_rom_b[i/2][i%2] !== 8'h00) nz++;
    checks++;
    if (nz != 0 || loaded !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL midreset_async: nonzero=%0d loaded=%b ready=%b state=%0d exp 0 0 1 0", nz, loaded, in_ready, dbg_state);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    push_exp(8'd70);
    send_frame(8'd70, 8'h00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (load_done !== 1'b1 || loaded !== 1'b1) begin
      failures++; $display("FAIL midreset_commit: done=%b loaded=%b exp 1 1", load_done, loaded);
    end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      a = (i < 10) ? data_rom_w[i/5][i%5] : data_rom_b[(i-10)/2][(i-10)%2];
      if (a !== e) mism++;
    end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL midreset_matrix: mismatches=%0d exp 0", mism); end
    @(posedge clk); #1;
  endtask

  task automatic test_err_count();
    checks++;
    if (err_cnt != EXP_ERRS) begin
      failures++; $display("FAIL err_pulses: got %0d exp %0d", err_cnt, EXP_ERRS);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_good_frame();
`ifdef MATRIX_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_discard();
    test_back_to_back();
    test_reset_mid();
    test_err_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
